// File: rtl/wb_trace_tx.sv
// Writeback trace transmitter: queues register-write events in a small FIFO and
// ships each one as a 5-byte UART 8N1 frame ({4'hA, rd}, data MSB byte first).
module wb_trace_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic [3:0]                    wb_rd,
    input  logic [31:0]                   wb_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [35:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf_q;

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx, byte_idx;
    logic [39:0]   frame;
    logic [7:0]    cur_byte;
    logic          tx_q;

    logic full, pop, push;

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (state == S_IDLE) && (count != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push = wb_valid && (!full || pop);

    // NOTE: the event storage is deliberately not reset; pointers and count
    // define validity, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= {wb_rd, wb_data};
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wb_valid && !push) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        cur_byte = frame[7:0];
        case (byte_idx)
            3'd0:    cur_byte = frame[39:32];
            3'd1:    cur_byte = frame[31:24];
            3'd2:    cur_byte = frame[23:16];
            3'd3:    cur_byte = frame[15:8];
            default: cur_byte = frame[7:0];
        endcase
    end

    // tx is loaded alongside each state change so the line level always
    // matches the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud <= '0;
                    tx_q <= 1'b1;
                    if (pop) begin
                        frame    <= {4'hA, mem[rd_ptr]};
                        byte_idx <= '0;
                        state    <= S_START;
                        tx_q     <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud == BAUD_MAX) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx_q    <= cur_byte[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud == BAUD_MAX) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    if (baud == BAUD_MAX) begin
                        baud <= '0;
                        if (byte_idx < 3'd4) begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= S_START;
                            tx_q     <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = (count != '0) || (state != S_IDLE);
    assign overflow   = ovf_q;
    assign fifo_count = count;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Bench for wb_trace_tx: drives writeback events, decodes the serial line with a
// behavioural UART receiver and compares against frames built from the events.
module tb_wb_trace_tx;

    localparam int C  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb_valid = 1'b0;
    logic [3:0]    wb_rd = '0;
    logic [31:0]   wb_data = '0;
    logic          tx, busy, overflow;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cap_cyc = 0;

    logic [35:0] stim_q[$];
    logic [35:0] exp_q[$];
    logic [7:0]  rx_q[$];
    int          rx_t[$];

    wb_trace_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Byte k of the frame for an event: sync/rd byte first, then data MSB first.
    function automatic logic [7:0] model_byte(input logic [35:0] ev, input int k);
        if (k == 0) return {4'hA, ev[35:32]};
        return 8'(ev[31:0] >> (8 * (4 - k)));
    endfunction

    task automatic clear_q();
        stim_q.delete();
        exp_q.delete();
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic drive_stim();
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            wb_valid = 1'b1;
            {wb_rd, wb_data} = stim_q[i];
            if (i == 0) cap_cyc = cyc + 1;
        end
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic rx_bytes(input int n);
        logic [7:0] b;
        int w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            @(negedge clk);
            while (tx !== 1'b0 && w < 2000) begin
                @(negedge clk);
                w++;
            end
            total++;
            if (tx !== 1'b0) begin
                bad++;
                $display("FAIL rx_timeout byte %0d: line stayed %b, required start bit 0", k, tx);
                return;
            end
            rx_t.push_back(cyc);
            repeat (C + C / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                b[i] = tx;
                if (i < 7) repeat (C) @(negedge clk);
            end
            repeat (C) @(negedge clk);
            total++;
            if (tx !== 1'b1) begin
                bad++;
                $display("FAIL stop_bit byte %0d: got %b required 1", k, tx);
            end
            rx_q.push_back(b);
        end
    endtask

    task automatic check_frames(input string name);
        total++;
        if (rx_q.size() != 5 * exp_q.size()) begin
            bad++;
            $display("FAIL %s byte_count: got %0d required %0d", name, rx_q.size(), 5 * exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int k = 0; k < 5; k++) begin
                if (5 * i + k < rx_q.size()) begin
                    total++;
                    if (rx_q[5 * i + k] !== model_byte(exp_q[i], k)) begin
                        bad++;
                        $display("FAIL %s frame %0d byte %0d: got %h required %h",
                                 name, i, k, rx_q[5 * i + k], model_byte(exp_q[i], k));
                    end
                end
            end
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        total++;
        if (fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        clear_q();
        stim_q.push_back({4'd3, 32'h1234_5678});
        exp_q = stim_q;
        fork
            drive_stim();
            rx_bytes(5);
        join
        if (rx_t.size() > 0) begin
            total++;
            if (rx_t[0] - cap_cyc != 1) begin
                bad++;
                $display("FAIL single_latency: start bit %0d edges after capture, required 1", rx_t[0] - cap_cyc);
            end
        end
        check_frames("single");
        while (cyc < cap_cyc + 200) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold: got %b required 1 at edge +200", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got %b required 0 at edge +201", busy); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        clear_q();
        stim_q.push_back({4'd1, 32'hDEAD_BEEF});
        stim_q.push_back({4'd15, 32'h0000_0001});
        exp_q = stim_q;
        fork
            drive_stim();
            rx_bytes(10);
        join
        check_frames("b2b");
        if (rx_t.size() >= 6) begin
            total++;
            if (rx_t[5] - rx_t[0] != 50 * C + 1) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d edges required %0d", rx_t[5] - rx_t[0], 50 * C + 1);
            end
        end
        wait_idle();
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({tx, busy, fifo_count} !== {1'b1, 1'b0, CW'(0)}) begin
                bad++;
                $display("FAIL ignored cycle %0d: tx=%b busy=%b count=%0d required 1 0 0",
                         i, tx, busy, fifo_count);
            end
            wb_valid = 1'b0;
            wb_rd    = 4'($urandom);
            wb_data  = $urandom;
        end
    endtask

    task automatic test_overflow();
        int peak = 0;
        int n = D + 2;
        clear_q();
        for (int i = 0; i < n; i++) stim_q.push_back({4'($urandom), 32'(i)});
        // A burst into an idle block keeps the first FIFO_DEPTH+1 events.
        for (int i = 0; i < n && i < D + 1; i++) exp_q.push_back(stim_q[i]);
        fork
            drive_stim();
            rx_bytes(5 * (D + 1));
            begin
                @(negedge clk);
                for (int j = 0; j < n + 2; j++) begin
                    @(negedge clk);
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                    if (j == D) begin
                        total++;
                        if (overflow !== 1'b0) begin
                            bad++;
                            $display("FAIL ovf_early: overflow=%b after edge %0d required 0", overflow, j);
                        end
                    end
                    if (j == D + 1) begin
                        total++;
                        if (overflow !== 1'b1) begin
                            bad++;
                            $display("FAIL ovf_set: overflow=%b after edge %0d required 1", overflow, j);
                        end
                    end
                end
            end
        join
        total++;
        if (peak != D) begin bad++; $display("FAIL ovf_peak: got %0d required %0d", peak, D); end
        check_frames("overflow");
        begin
            bit extra = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (tx === 1'b0) extra = 1'b1;
            end
            total++;
            if (extra) begin bad++; $display("FAIL ovf_extra_frame: got start bit required none"); end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        clear_q();
        for (int i = 0; i < 4; i++) stim_q.push_back({4'($urandom), 32'($urandom)});
        drive_stim();
        while (cyc < cap_cyc + 1 + 23 * C) @(negedge clk);
        total++;
        if ({overflow, busy, fifo_count} !== {1'b1, 1'b1, CW'(3)}) begin
            bad++;
            $display("FAIL mid_pre: ovf=%b busy=%b count=%0d required 1 1 3", overflow, busy, fifo_count);
        end
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 4'($urandom);
        wb_data  = $urandom;
        @(negedge clk);
        total++;
        if ({tx, fifo_count, overflow, busy} !== {1'b1, CW'(0), 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: tx=%b count=%0d ovf=%b busy=%b required 1 0 0 0",
                     tx, fifo_count, overflow, busy);
        end
        reset    = 1'b0;
        wb_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({tx, fifo_count, busy} !== {1'b1, CW'(0), 1'b0}) begin
            bad++;
            $display("FAIL mid_no_capture: tx=%b count=%0d busy=%b required 1 0 0", tx, fifo_count, busy);
        end
        clear_q();
        stim_q.push_back({4'($urandom), 32'($urandom)});
        exp_q = stim_q;
        fork
            drive_stim();
            rx_bytes(5);
        join
        check_frames("after_reset");
        wait_idle();
    endtask

    task automatic test_wrap();
        for (int e = 0; e < 20; e++) begin
            clear_q();
            stim_q.push_back({4'($urandom), 32'($urandom)});
            exp_q = stim_q;
            fork
                drive_stim();
                rx_bytes(5);
            join
            check_frames($sformatf("wrap%0d", e));
            while (cyc < cap_cyc + 300) @(negedge clk);
        end
        total++;
        if ({busy, fifo_count} !== {1'b0, CW'(0)}) begin
            bad++;
            $display("FAIL wrap_end: busy=%b count=%0d required 0 0", busy, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
